// File: rtl/cmos_16_8bit_tx_pkg.sv
// cmos_pkg: shared FSM state type, default DVP timing and counter width
// Used by cmos_timing_gen and cmos_16_8bit_tx.
package cmos_pkg;
    localparam int CNT_W           = 12;
    localparam int H_ACTIVE_DEF    = 640;
    localparam int H_BLANK_DEF     = 144;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int VSYNC_LINES_DEF = 3;
    localparam int V_BACK_DEF      = 17;
    localparam int V_FRONT_DEF     = 10;
    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} dvp_state_t;
endpackage

// File: rtl/cmos_16_8bit_tx_timing_gen.sv
// cmos_timing_gen: line/frame counters and frame-region FSM for the DVP transmitter
// Ports: cam_pclk clock, rst sync active-high reset, enable frame request,
//        state current region, h_cnt cycle within line, line_end last cycle of a line,
//        frame_end last cycle of a frame.
module cmos_timing_gen
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_BLANK     = H_BLANK_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int VSYNC_LINES = VSYNC_LINES_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter int V_FRONT     = V_FRONT_DEF
) (
    input  logic             cam_pclk,
    input  logic             rst,
    input  logic             enable,
    output dvp_state_t       state,
    output logic [CNT_W-1:0] h_cnt,
    output logic             line_end,
    output logic             frame_end
);
    localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(VSYNC_LINES - 1);
    localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(VSYNC_LINES + V_BACK - 1);
    localparam logic [CNT_W-1:0] VA_LAST = CNT_W'(VSYNC_LINES + V_BACK + V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VF_LAST = CNT_W'(FRAME_LINES - 1);
    logic [CNT_W-1:0] v_cnt;
    assign line_end  = state != IDLE && h_cnt == H_LAST;
    assign frame_end = line_end && v_cnt == VF_LAST;
    // Counters rest at 0 in IDLE so the first VSYNC cycle starts at h_cnt=v_cnt=0.
    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == IDLE) begin
            if (enable) state <= VSYNC;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + 1'b1;
            if (line_end) v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
            if (line_end)
                case (state)
                    VSYNC:   if (v_cnt == VS_LAST) state <= VBACK;
                    VBACK:   if (v_cnt == VB_LAST) state <= ACTIVE;
                    ACTIVE:  if (v_cnt == VA_LAST) state <= VFRONT;
                    default: if (frame_end) state <= enable ? VSYNC : IDLE;
                endcase
        end
    end
endmodule

// File: rtl/cmos_16_8bit_tx.sv
// cmos_16_8bit_tx: RGB565 valid/ready to 8-bit DVP byte stream, high byte first
// Ports: cam_pclk clock, rst sync active-high reset, enable frame request,
//        pix_data/pix_valid/pix_ready pixel handshake (pix_ready combinational),
//        cam_vsync/cam_href/cam_data registered DVP outputs,
//        frame_start pulse after VSYNC entry, underflow pulse on a missed pixel.
module cmos_16_8bit_tx
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_BLANK     = H_BLANK_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int VSYNC_LINES = VSYNC_LINES_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter int V_FRONT     = V_FRONT_DEF
) (
    input  logic        cam_pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic        underflow
);
    localparam logic [CNT_W-1:0] ACT_LEN = CNT_W'(2 * H_ACTIVE);
    dvp_state_t       state;
    logic [CNT_W-1:0] h_cnt;
    logic             line_end;
    logic             frame_end;
    logic             unused_frame_end;
    logic             act;
    logic [7:0]       hold;
    cmos_timing_gen #(
        .H_ACTIVE(H_ACTIVE),
        .H_BLANK(H_BLANK),
        .V_ACTIVE(V_ACTIVE),
        .VSYNC_LINES(VSYNC_LINES),
        .V_BACK(V_BACK),
        .V_FRONT(V_FRONT)
    ) u_timing (
        .cam_pclk(cam_pclk),
        .rst(rst),
        .enable(enable),
        .state(state),
        .h_cnt(h_cnt),
        .line_end(line_end),
        .frame_end(frame_end)
    );
    assign unused_frame_end = frame_end;
    assign act       = state == ACTIVE && h_cnt < ACT_LEN;
    assign pix_ready = !rst && act && !h_cnt[0];
    // Even active cycles emit the fresh high byte, odd ones the held low byte;
    // a missed pixel turns both into 00. frame_start keys off the VSYNC edge
    // seen through the previous cam_vsync value.
    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= 8'h00;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            hold        <= 8'h00;
        end else begin
            cam_vsync   <= state == VSYNC;
            frame_start <= state == VSYNC && !cam_vsync;
            cam_href    <= act;
            cam_data    <= !act ? 8'h00 : h_cnt[0] ? hold : pix_valid ? pix_data[15:8] : 8'h00;
            hold        <= line_end ? 8'h00 : pix_ready ? (pix_valid ? pix_data[7:0] : 8'h00) : hold;
            underflow   <= pix_ready && !pix_valid;
        end
    end
endmodule

// File: tb/tb_cmos_16_8bit_tx.sv
// tb_cmos_16_8bit_tx: directed self-checking bench for the DVP transmitter
module tb_cmos_16_8bit_tx;
    logic        cam_pclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] pix_data = 16'hFFFF;
    logic        pix_valid = 1'b1;
    logic        pix_ready;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_start;
    logic        underflow;
    int n_chk = 0;
    int n_fail = 0;
    int t = -1;
    int nfr = 1000;
    int drop_j = -1;
    logic [15:0] tab [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                             16'h0FED, 16'hCBA9, 16'h8765, 16'h4321};
    cmos_16_8bit_tx #(
        .H_ACTIVE(4), .H_BLANK(4), .V_ACTIVE(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .cam_pclk(cam_pclk), .rst(rst), .enable(enable),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .frame_start(frame_start), .underflow(underflow)
    );
    always #5 cam_pclk = ~cam_pclk;
    // Frame model: 5 lines of 12 cycles; lines 0 VSYNC, 1 VBACK, 2-3 ACTIVE, 4 VFRONT.
    // c is the cycle index from the first VSYNC cycle; -1 means IDLE.
    function automatic int reg_of(int c);
        if (c < 0 || c >= nfr * 60) return -1;
        return (c % 60) / 12;
    endfunction
    function automatic int jj(int c);
        return (reg_of(c) - 2) * 4 + (c % 12) / 2;
    endfunction
    function automatic logic e_ready(int c);
        int r;
        r = reg_of(c);
        return (r == 2 || r == 3) && (c % 12) < 8 && (c % 2) == 0;
    endfunction
    function automatic logic e_href(int c);
        int r;
        r = reg_of(c - 1);
        return (r == 2 || r == 3) && ((c - 1) % 12) < 8;
    endfunction
    function automatic logic [7:0] e_data(int c);
        logic [15:0] w;
        if (!e_href(c) || jj(c - 1) == drop_j) return 8'h00;
        w = tab[jj(c - 1)];
        return ((c - 1) % 2) != 0 ? w[7:0] : w[15:8];
    endfunction
    function automatic logic e_vsync(int c);
        return reg_of(c - 1) == 0;
    endfunction
    function automatic logic e_fs(int c);
        return reg_of(c - 1) == 0 && ((c - 1) % 60) == 0;
    endfunction
    function automatic logic e_uf(int c);
        return e_ready(c - 1) && jj(c - 1) == drop_j;
    endfunction
    task automatic tick();
        @(negedge cam_pclk);
        t++;
        pix_valid = !(e_ready(t) && jj(t) == drop_j);
        pix_data  = e_ready(t) ? tab[jj(t)] : 16'hFFFF;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        repeat (4) begin
            @(negedge cam_pclk);
            n_chk++;
            if ({pix_ready, cam_vsync, cam_href, cam_data, frame_start, underflow} !== 13'h0) begin
                n_fail++;
                $display("FAIL reset_outputs got %h required 0", {pix_ready, cam_vsync, cam_href, cam_data, frame_start, underflow});
            end
        end
        rst = 1'b0;
        t = -1;
        nfr = 1000;
        drop_j = -1;
        repeat (14) begin
            tick();
            n_chk++;
            if (frame_start !== e_fs(t)) begin
                n_fail++;
                $display("FAIL reset_frame_start t=%0d got %b required %b", t, frame_start, e_fs(t));
            end
            n_chk++;
            if (cam_vsync !== e_vsync(t)) begin
                n_fail++;
                $display("FAIL reset_vsync t=%0d got %b required %b", t, cam_vsync, e_vsync(t));
            end
        end
    endtask
    task automatic test_streaming();
        int hs = 0;
        int fs_a = -1;
        int fs_b = -1;
        while (t < 121) begin
            tick();
            n_chk++;
            if (pix_ready !== e_ready(t)) begin
                n_fail++;
                $display("FAIL stream_ready t=%0d got %b required %b", t, pix_ready, e_ready(t));
            end
            n_chk++;
            if (cam_href !== e_href(t)) begin
                n_fail++;
                $display("FAIL stream_href t=%0d got %b required %b", t, cam_href, e_href(t));
            end
            n_chk++;
            if (cam_data !== e_data(t)) begin
                n_fail++;
                $display("FAIL stream_data t=%0d got %h required %h", t, cam_data, e_data(t));
            end
            n_chk++;
            if (cam_vsync !== e_vsync(t)) begin
                n_fail++;
                $display("FAIL stream_vsync t=%0d got %b required %b", t, cam_vsync, e_vsync(t));
            end
            n_chk++;
            if (frame_start !== e_fs(t)) begin
                n_fail++;
                $display("FAIL stream_frame_start t=%0d got %b required %b", t, frame_start, e_fs(t));
            end
            n_chk++;
            if (underflow !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_underflow t=%0d got %b required 0", t, underflow);
            end
            if (t >= 60 && t < 120 && pix_ready && pix_valid) hs++;
            if (frame_start) begin
                fs_a = fs_b;
                fs_b = t;
            end
        end
        n_chk++;
        if (hs != 8) begin
            n_fail++;
            $display("FAIL stream_handshakes got %0d required 8", hs);
        end
        n_chk++;
        if (fs_b - fs_a != 60) begin
            n_fail++;
            $display("FAIL stream_period got %0d required 60", fs_b - fs_a);
        end
    endtask
    task automatic test_underflow();
        int uf_cnt = 0;
        int href_cnt = 0;
        drop_j = 1;
        while (t < 179) begin
            tick();
            n_chk++;
            if (cam_data !== e_data(t)) begin
                n_fail++;
                $display("FAIL uf_data t=%0d got %h required %h", t, cam_data, e_data(t));
            end
            n_chk++;
            if (underflow !== e_uf(t)) begin
                n_fail++;
                $display("FAIL uf_pulse t=%0d got %b required %b", t, underflow, e_uf(t));
            end
            n_chk++;
            if (pix_ready !== e_ready(t)) begin
                n_fail++;
                $display("FAIL uf_ready t=%0d got %b required %b", t, pix_ready, e_ready(t));
            end
            if (underflow) uf_cnt++;
            if (cam_href) href_cnt++;
        end
        n_chk++;
        if (uf_cnt != 1) begin
            n_fail++;
            $display("FAIL uf_count got %0d required 1", uf_cnt);
        end
        n_chk++;
        if (href_cnt != 16) begin
            n_fail++;
            $display("FAIL uf_href_cycles got %0d required 16", href_cnt);
        end
        drop_j = -1;
    endtask
    task automatic test_enable_drop();
        int fs_cnt = 0;
        while (t < 210) tick();
        enable = 1'b0;
        nfr = 4;
        while (t < 260) begin
            tick();
            n_chk++;
            if ({cam_vsync, cam_href, cam_data, pix_ready} !== {e_vsync(t), e_href(t), e_data(t), e_ready(t)}) begin
                n_fail++;
                $display("FAIL endrop_outputs t=%0d got %h required %h", t, {cam_vsync, cam_href, cam_data, pix_ready},
                         {e_vsync(t), e_href(t), e_data(t), e_ready(t)});
            end
            if (frame_start) fs_cnt++;
        end
        n_chk++;
        if (fs_cnt != 0) begin
            n_fail++;
            $display("FAIL endrop_frame_start got %0d required 0", fs_cnt);
        end
        n_chk++;
        if ({pix_ready, cam_vsync, cam_href, cam_data, frame_start, underflow} !== 13'h0) begin
            n_fail++;
            $display("FAIL endrop_idle got %h required 0", {pix_ready, cam_vsync, cam_href, cam_data, frame_start, underflow});
        end
    endtask
    task automatic test_reset_midline();
        rst = 1'b1;
        repeat (2) @(negedge cam_pclk);
        enable = 1'b1;
        rst = 1'b0;
        t = -1;
        nfr = 1000;
        while (t < 29) begin
            tick();
            n_chk++;
            if ({cam_href, cam_data} !== {e_href(t), e_data(t)}) begin
                n_fail++;
                $display("FAIL midrst_pre t=%0d got %h required %h", t, {cam_href, cam_data}, {e_href(t), e_data(t)});
            end
        end
        n_chk++;
        if ({cam_href, cam_data} !== 9'h19A) begin
            n_fail++;
            $display("FAIL midrst_href5 got %h required 19a", {cam_href, cam_data});
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if ({pix_ready, cam_href, cam_data} !== 10'h0) begin
            n_fail++;
            $display("FAIL midrst_abort got %h required 0", {pix_ready, cam_href, cam_data});
        end
        rst = 1'b0;
        t = -1;
        repeat (2) tick();
        n_chk++;
        if ({frame_start, cam_vsync} !== 2'b11) begin
            n_fail++;
            $display("FAIL midrst_restart got %b required 11", {frame_start, cam_vsync});
        end
    endtask
    task automatic test_loopback();
        logic [7:0] hi = 8'h00;
        logic       half = 1'b0;
        int         w = 0;
        while (t < 60) begin
            tick();
            if (cam_href) begin
                if (half) begin
                    n_chk++;
                    if ({hi, cam_data} !== tab[w % 8]) begin
                        n_fail++;
                        $display("FAIL loopback_word %0d got %h required %h", w, {hi, cam_data}, tab[w % 8]);
                    end
                    w++;
                end
                hi = cam_data;
                half = !half;
            end
        end
        n_chk++;
        if (w != 8) begin
            n_fail++;
            $display("FAIL loopback_count got %0d required 8", w);
        end
    endtask
    initial begin
        test_reset();
        test_streaming();
        test_underflow();
        test_enable_drop();
        test_reset_midline();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
